// File: rtl/lg_pkg.sv
// lg_pkg: shared types and sizing for the register-index sequencer.
// Default widths, step direction encoding and remaining-count width.
package lg_pkg;

  localparam int W_DEF  = 3;
  localparam int LW_DEF = 2;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  // remaining-step counter must hold a full 2**W run
  function automatic int rem_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/lg_step.sv
// lg_step: next register index for one up/down move.
// Only the active field (low LW bits or all W bits) counts.
module lg_step
  import lg_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LW = LW_DEF
) (
  input  logic [W-1:0] idx,
  input  logic         gr,
  input  logic         dir,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LMASK =
    W'((2 ** LW) - 1);

  logic [W-1:0] mask;
  logic [W-1:0] moved;
  logic [W-1:0] field;

  // the carry may escape the field; masking restores the held bits
  always_comb begin
    mask  = gr ? '1 : LMASK;
    moved = (dir == DOWN) ? idx - W'(1)
                          : idx + W'(1);
    field = idx & mask;
    nxt   = (idx & ~mask) | (moved & mask);
    wrap  = (dir == DOWN) ? (field == '0)
                          : (field == mask);
  end

endmodule

// File: rtl/lg_seq.sv
// lg_seq: register-index sequencer for load/store-multiple style ops.
// Holds index, remaining count and done/wrap pulses; decodes idx.
module lg_seq
  import lg_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LW = LW_DEF
) (
  input  logic                  clk_,
  input  logic                  reset,
  input  logic                  ld_ir,
  input  logic                  ld_grp,
  input  logic [W-1:0]          ir_idx,
  input  logic [W-1:0]          grp_base,
  input  logic [rem_w(W)-1:0]   len,
  input  logic                  step,
  input  logic                  gr,
  input  logic                  dir,
  output logic [W-1:0]          idx,
  output logic [(2**LW)-1:0]    dec,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  localparam int RW = rem_w(W);

  logic [RW-1:0] rem;
  logic [W-1:0]  nxt;
  logic          nxt_wrap;

  lg_step #(
    .W  (W),
    .LW (LW)
  ) u_step (
    .idx  (idx),
    .gr   (gr),
    .dir  (dir),
    .nxt  (nxt),
    .wrap (nxt_wrap)
  );

  // reset beats group load beats ir load beats step
  always_ff @(posedge clk_) begin
    if (reset) begin
      idx  <= '0;
      rem  <= '0;
      done <= 1'b0;
      wrap <= 1'b0;
    end else if (ld_grp) begin
      idx  <= grp_base;
      rem  <= len;
      done <= 1'b0;
      wrap <= 1'b0;
    end else if (ld_ir) begin
      idx  <= ir_idx;
      rem  <= len;
      done <= 1'b0;
      wrap <= 1'b0;
    end else if (step) begin
      idx  <= nxt;
      wrap <= nxt_wrap;
      if (rem != '0) begin
        rem  <= rem - RW'(1);
        done <= (rem == RW'(1));
      end else begin
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // busy derives from registered rem only
  assign busy = (rem != '0);

  // one-hot decode of the low field of the registered index
  always_comb begin
    dec = '0;
    dec[idx[LW-1:0]] = 1'b1;
  end

endmodule

// File: tb/tb_lg_seq.sv
// tb_lg_seq: directed and random checks of lg_seq against a model.
// Instance a uses default widths, instance b uses W=5 LW=3.
module tb_lg_seq;

  typedef struct {
    int idx;
    int rem;
    bit done;
    bit wrap;
  } mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_ld_ir, a_ld_grp;
  logic [2:0] a_ir_idx, a_grp_base;
  logic [3:0] a_len;
  logic       a_step, a_gr, a_dir;
  logic [2:0] a_idx;
  logic [3:0] a_dec;
  logic       a_busy, a_done, a_wrap;

  logic       b_reset, b_ld_ir, b_ld_grp;
  logic [4:0] b_ir_idx, b_grp_base;
  logic [5:0] b_len;
  logic       b_step, b_gr, b_dir;
  logic [4:0] b_idx;
  logic [7:0] b_dec;
  logic       b_busy, b_done, b_wrap;

  lg_seq u_a (
    .clk_     (clk),
    .reset    (a_reset),
    .ld_ir    (a_ld_ir),
    .ld_grp   (a_ld_grp),
    .ir_idx   (a_ir_idx),
    .grp_base (a_grp_base),
    .len      (a_len),
    .step     (a_step),
    .gr       (a_gr),
    .dir      (a_dir),
    .idx      (a_idx),
    .dec      (a_dec),
    .busy     (a_busy),
    .done     (a_done),
    .wrap     (a_wrap)
  );

  lg_seq #(
    .W  (5),
    .LW (3)
  ) u_b (
    .clk_     (clk),
    .reset    (b_reset),
    .ld_ir    (b_ld_ir),
    .ld_grp   (b_ld_grp),
    .ir_idx   (b_ir_idx),
    .grp_base (b_grp_base),
    .len      (b_len),
    .step     (b_step),
    .gr       (b_gr),
    .dir      (b_dir),
    .idx      (b_idx),
    .dec      (b_dec),
    .busy     (b_busy),
    .done     (b_done),
    .wrap     (b_wrap)
  );

  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;
  mst_t ma = '{0, 0, 1'b0, 1'b0};
  mst_t mb = '{0, 0, 1'b0, 1'b0};

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, exp);
    end
  endtask

  // index arithmetic on plain integers: field = idx mod n
  function automatic mst_t mnext(
    input mst_t s, input int w, input int lw,
    input bit rst, input bit ldg, input bit ldi,
    input int base, input int iri, input int ln,
    input bit stp, input bit g, input bit d);
    mst_t r;
    int   n;
    int   lo;
    r = s;
    if (rst) begin
      r = '{0, 0, 1'b0, 1'b0};
    end else if (ldg || ldi) begin
      r.idx  = ldg ? base : iri;
      r.rem  = ln;
      r.done = 1'b0;
      r.wrap = 1'b0;
    end else if (stp) begin
      n      = g ? (1 << w) : (1 << lw);
      lo     = s.idx % n;
      r.wrap = d ? (lo == 0) : (lo == n - 1);
      r.idx  = s.idx - lo +
               (d ? (lo + n - 1) % n : (lo + 1) % n);
      r.done = (s.rem == 1);
      r.rem  = (s.rem > 0) ? s.rem - 1 : 0;
    end else begin
      r.done = 1'b0;
      r.wrap = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    ma = mnext(ma, 3, 2, a_reset, a_ld_grp, a_ld_ir,
               int'(a_grp_base), int'(a_ir_idx),
               int'(a_len), a_step, a_gr, a_dir);
    mb = mnext(mb, 5, 3, b_reset, b_ld_grp, b_ld_ir,
               int'(b_grp_base), int'(b_ir_idx),
               int'(b_len), b_step, b_gr, b_dir);
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_idx", int'(a_idx), ma.idx);
      chk("a_busy", int'(a_busy), int'(ma.rem != 0));
      chk("a_done", int'(a_done), int'(ma.done));
      chk("a_wrap", int'(a_wrap), int'(ma.wrap));
      chk("a_dec", int'(a_dec), 1 << (ma.idx % 4));
      chk("b_idx", int'(b_idx), mb.idx);
      chk("b_busy", int'(b_busy), int'(mb.rem != 0));
      chk("b_done", int'(b_done), int'(mb.done));
      chk("b_wrap", int'(b_wrap), int'(mb.wrap));
      chk("b_dec", int'(b_dec), 1 << (mb.idx % 8));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_idle();
    a_reset  = 1'b0;
    a_ld_ir  = 1'b0;
    a_ld_grp = 1'b0;
    a_step   = 1'b0;
  endtask

  task automatic a_lit(input string nm, input int i,
                       input int dc, input int bz,
                       input int dn, input int wr);
    chk({nm, "_idx"}, int'(a_idx), i);
    chk({nm, "_dec"}, int'(a_dec), dc);
    chk({nm, "_busy"}, int'(a_busy), bz);
    chk({nm, "_done"}, int'(a_done), dn);
    chk({nm, "_wrap"}, int'(a_wrap), wr);
  endtask

  initial begin
    a_reset = 1'b1; a_ld_ir = 1'b0; a_ld_grp = 1'b0;
    a_ir_idx = '0; a_grp_base = '0; a_len = '0;
    a_step = 1'b0; a_gr = 1'b1; a_dir = 1'b0;
    b_reset = 1'b1; b_ld_ir = 1'b0; b_ld_grp = 1'b0;
    b_ir_idx = '0; b_grp_base = '0; b_len = '0;
    b_step = 1'b0; b_gr = 1'b1; b_dir = 1'b0;
    tick();
    tick();
    a_lit("rst", 0, 1, 0, 0, 0);

    a_idle();
    a_ld_ir = 1'b1; a_ir_idx = 3'd5; a_len = 4'd0;
    tick();
    a_lit("ldir", 5, 2, 0, 0, 0);
    a_idle();
    tick();
    a_lit("ldir_idle", 5, 2, 0, 0, 0);

    a_ld_grp = 1'b1; a_grp_base = 3'd4; a_len = 4'd4;
    a_gr = 1'b1; a_dir = 1'b0;
    tick();
    a_lit("grp", 4, 1, 1, 0, 0);
    a_idle();
    a_step = 1'b1;
    tick();
    a_lit("grp_s1", 5, 2, 1, 0, 0);
    tick();
    a_lit("grp_s2", 6, 4, 1, 0, 0);
    tick();
    a_lit("grp_s3", 7, 8, 1, 0, 0);
    tick();
    a_lit("grp_s4", 0, 1, 0, 1, 1);
    a_idle();
    tick();
    a_lit("grp_after", 0, 1, 0, 0, 0);

    a_ld_ir = 1'b1; a_ir_idx = 3'd7; a_len = 4'd0;
    tick();
    a_idle();
    a_step = 1'b1; a_gr = 1'b0; a_dir = 1'b0;
    tick();
    a_lit("low_up", 4, 1, 0, 0, 1);
    a_dir = 1'b1;
    tick();
    a_lit("low_dn", 7, 8, 0, 0, 1);

    a_idle();
    a_ld_ir = 1'b1; a_ir_idx = 3'd1;
    a_ld_grp = 1'b1; a_grp_base = 3'd6;
    a_len = 4'd3; a_step = 1'b1; a_gr = 1'b1;
    a_dir = 1'b0;
    tick();
    a_lit("both", 6, 4, 1, 0, 0);
    a_idle();
    a_step = 1'b1;
    tick();
    a_lit("pre_rst", 7, 8, 1, 0, 0);
    a_reset = 1'b1;
    tick();
    a_lit("mid_rst", 0, 1, 0, 0, 0);
    a_reset = 1'b0;
    tick();
    a_lit("free", 1, 2, 0, 0, 0);
    a_idle();

    b_reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      a_reset    = ($urandom_range(0, 99) < 2);
      a_ld_grp   = ($urandom_range(0, 99) < 5);
      a_ld_ir    = ($urandom_range(0, 99) < 8);
      a_step     = ($urandom_range(0, 99) < 75);
      a_gr       = $urandom_range(0, 1) == 1;
      a_dir      = $urandom_range(0, 1) == 1;
      a_ir_idx   = 3'($urandom);
      a_grp_base = 3'($urandom);
      a_len      = 4'($urandom_range(0, 9));
      b_reset    = ($urandom_range(0, 99) < 2);
      b_ld_grp   = ($urandom_range(0, 99) < 5);
      b_ld_ir    = ($urandom_range(0, 99) < 8);
      b_step     = ($urandom_range(0, 99) < 75);
      b_gr       = $urandom_range(0, 1) == 1;
      b_dir      = $urandom_range(0, 1) == 1;
      b_ir_idx   = 5'($urandom);
      b_grp_base = 5'($urandom);
      b_len      = 6'($urandom_range(0, 12));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
